// File: rtl/pc_return_stack_pkg.sv
// ----------------------------------------------------------------------------
// rstack_pkg
// Shared sizing and types for the PC return stack.
//   RS_AW      : width of one stored return address (matches the PC width)
//   RS_DEPTH   : number of stack entries (power of two, >= 2)
//   ret_addr_t : one stored return address
//   rs_level_t : occupancy count, able to hold 0..RS_DEPTH
// ----------------------------------------------------------------------------
package rstack_pkg;

    localparam int RS_AW    = 5;
    localparam int RS_DEPTH = 8;

    typedef logic [RS_AW-1:0]               ret_addr_t;
    typedef logic [$clog2(RS_DEPTH+1)-1:0]  rs_level_t;

endpackage : rstack_pkg

// File: rtl/pc_return_stack.sv
// ----------------------------------------------------------------------------
// pc_return_stack
// LIFO of program-counter return addresses. CALL pushes the return address,
// RET pops the top entry, which is presented combinationally on `top` in the
// same cycle as the pop so the PC counter can load it at that clock edge.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_       in   1    asynchronous reset, active low
//   push       in   1    push push_data this cycle (CALL)
//   push_data  in   AW   return address to store
//   pop        in   1    pop top entry this cycle (RET)
//   top        out  AW   current top of stack, 0 when empty
//   empty      out  1    no entries held
//   full       out  1    DEPTH entries held
//   level      out  LW   number of entries held (0..DEPTH)
//   err_clr    in   1    clears ovf/unf             (RSTACK_ERR_EN only)
//   ovf        out  1    sticky: push seen while full (RSTACK_ERR_EN only)
//   unf        out  1    sticky: pop seen while empty (RSTACK_ERR_EN only)
//
// Configuration
//   RSTACK_ERR_EN : when defined, adds the sticky overflow/underflow flags and
//                   their clear input. When undefined those ports do not exist
//                   and overflow/underflow are silently dropped.
// ----------------------------------------------------------------------------
module pc_return_stack
    import rstack_pkg::*;
#(
    parameter int  AW    = RS_AW,
    parameter int  DEPTH = RS_DEPTH,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          push,
    input  logic [AW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
`ifdef RSTACK_ERR_EN
    ,
    input  logic          err_clr,
    output logic          ovf,
    output logic          unf
`endif
);

    logic [AW-1:0] mem_q [DEPTH];
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          wr_en_s;
    logic [IW-1:0] wr_idx_s;
    logic [IW-1:0] top_idx_s;
    logic [LW-1:0] level_m1_s;
    logic          empty_s;
    logic          full_s;
`ifdef RSTACK_ERR_EN
    logic          ovf_q;
    logic          ovf_d;
    logic          unf_q;
    logic          unf_d;
`endif

    // Occupancy decode and the index of the current top entry.
    always_comb begin
        empty_s    = (level_q == {LW{1'b0}});
        full_s     = (level_q == LW'(DEPTH));
        level_m1_s = level_q - LW'(1);
        top_idx_s  = level_m1_s[IW-1:0];
    end

    // Next-state for level, the storage write port and the error flags.
    always_comb begin
        level_d  = level_q;
        wr_en_s  = 1'b0;
        wr_idx_s = level_q[IW-1:0];
`ifdef RSTACK_ERR_EN
        ovf_d    = ovf_q & ~err_clr;
        unf_d    = unf_q & ~err_clr;
`endif
        case ({push, pop})
            2'b11: begin
                if (!empty_s) begin
                    // Tail call: overwrite the top entry in place.
                    wr_en_s  = 1'b1;
                    wr_idx_s = top_idx_s;
                end else begin
                    // Nothing to pop: behaves as a plain push into slot 0.
                    wr_en_s  = 1'b1;
                    wr_idx_s = {IW{1'b0}};
                    level_d  = LW'(1);
`ifdef RSTACK_ERR_EN
                    unf_d    = 1'b1;
`endif
                end
            end
            2'b10: begin
                if (!full_s) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = level_q[IW-1:0];
                    level_d  = level_q + LW'(1);
                end else begin
`ifdef RSTACK_ERR_EN
                    ovf_d    = 1'b1;
`endif
                    level_d  = level_q;
                end
            end
            2'b01: begin
                if (!empty_s) begin
                    level_d  = level_m1_s;
                end else begin
`ifdef RSTACK_ERR_EN
                    unf_d    = 1'b1;
`endif
                    level_d  = level_q;
                end
            end
            default: begin
                level_d  = level_q;
            end
        endcase
    end

    // Occupancy register; reset discards every entry.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            level_q <= {LW{1'b0}};
        end else begin
            level_q <= level_d;
        end
    end

`ifdef RSTACK_ERR_EN
    // Sticky error flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`endif

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= push_data;
        end
    end

    // Top is read combinationally so it is valid in the same cycle as pop.
    always_comb begin
        if (empty_s) begin
            top = {AW{1'b0}};
        end else begin
            top = mem_q[top_idx_s];
        end
    end

    assign empty = empty_s;
    assign full  = full_s;
    assign level = level_q;

endmodule : pc_return_stack

// File: tb/tb_pc_return_stack.sv
module tb_pc_return_stack;
    import rstack_pkg::*;

    logic       clk;
    logic       rst_;
    logic       push;
    logic [4:0] push_data;
    logic       pop;
    logic [4:0] top;
    logic       empty;
    logic       full;
    logic [3:0] level;
`ifdef RSTACK_ERR_EN
    logic       err_clr;
    logic       ovf;
    logic       unf;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue, newest entry at the back.
    logic [4:0] stk[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    pc_return_stack dut (
        .clk       (clk),
        .rst_      (rst_),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .top       (top),
        .empty     (empty),
        .full      (full),
        .level     (level)
`ifdef RSTACK_ERR_EN
        ,
        .err_clr   (err_clr),
        .ovf       (ovf),
        .unf       (unf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] m_top();
        if (stk.size() == 0) return 5'h00;
        return stk[stk.size()-1];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".top"},   {3'b000, top},   {3'b000, m_top()});
        chk({tag, ".level"}, {4'b0000, level}, 8'(stk.size()));
        chk({tag, ".empty"}, {7'd0, empty},   {7'd0, (stk.size() == 0)});
        chk({tag, ".full"},  {7'd0, full},    {7'd0, (stk.size() == RS_DEPTH)});
`ifdef RSTACK_ERR_EN
        chk({tag, ".ovf"},   {7'd0, ovf},     {7'd0, m_ovf});
        chk({tag, ".unf"},   {7'd0, unf},     {7'd0, m_unf});
`endif
    endtask

    // Applies one cycle of stimulus and advances the model by the stack rules.
    task automatic step(input logic p, input logic [4:0] d, input logic q, input logic c);
        logic set_o;
        logic set_u;
        push = p; push_data = d; pop = q;
`ifdef RSTACK_ERR_EN
        err_clr = c;
`endif
        @(posedge clk);
        #1;
        set_o = 1'b0;
        set_u = 1'b0;
        if (p && q) begin
            if (stk.size() > 0) stk[stk.size()-1] = d;
            else begin stk.push_back(d); set_u = 1'b1; end
        end else if (p) begin
            if (stk.size() < RS_DEPTH) stk.push_back(d);
            else set_o = 1'b1;
        end else if (q) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else set_u = 1'b1;
        end
        m_ovf = set_o | (m_ovf & ~c);
        m_unf = set_u | (m_unf & ~c);
        push = 1'b0; pop = 1'b0;
`ifdef RSTACK_ERR_EN
        err_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; push_data = 5'h00;
`ifdef RSTACK_ERR_EN
        err_clr = 1'b0;
`endif
        do_reset();
        #1;
        check_all("reset");
        @(posedge clk); #1;
        rst_ = 1'b1;

        // 1. Basic LIFO order.
        step(1'b1, 5'h03, 1'b0, 1'b0);
        step(1'b1, 5'h11, 1'b0, 1'b0);
        step(1'b1, 5'h1F, 1'b0, 1'b0);
        check_all("t1_push3");
        chk("t1_top_1F", {3'b000, top}, 8'h1F);
        step(1'b0, 5'h00, 1'b1, 1'b0);
        chk("t1_pop_11", {3'b000, top}, 8'h11);
        step(1'b0, 5'h00, 1'b1, 1'b0);
        chk("t1_pop_03", {3'b000, top}, 8'h03);
        step(1'b0, 5'h00, 1'b1, 1'b0);
        check_all("t1_empty");
        chk("t1_empty_flag", {7'd0, empty}, 8'h01);

        // 2. Fill, then overflow is dropped.
        for (int i = 0; i < 8; i++) step(1'b1, 5'(i), 1'b0, 1'b0);
        check_all("t2_full");
        chk("t2_full_flag", {7'd0, full}, 8'h01);
        step(1'b1, 5'h15, 1'b0, 1'b0);
        check_all("t2_ovf");
        chk("t2_top_7", {3'b000, top}, 8'h07);
        chk("t2_level_8", {4'b0000, level}, 8'h08);
        for (int i = 0; i < 8; i++) step(1'b0, 5'h00, 1'b1, 1'b0);
        check_all("t2_drain");

        // 3. Underflow from empty, then clear.
        step(1'b0, 5'h00, 1'b1, 1'b0);
        check_all("t3_unf");
        step(1'b0, 5'h00, 1'b0, 1'b1);
        check_all("t3_clr");

        // 4. Tail-call replace, then pop exposes older entry.
        step(1'b1, 5'h09, 1'b0, 1'b0);
        step(1'b1, 5'h0A, 1'b0, 1'b0);
        step(1'b1, 5'h1C, 1'b1, 1'b0);
        check_all("t4_replace");
        chk("t4_top_1C", {3'b000, top}, 8'h1C);
        step(1'b0, 5'h00, 1'b1, 1'b0);
        chk("t4_top_09", {3'b000, top}, 8'h09);
        step(1'b0, 5'h00, 1'b1, 1'b0);
        // Simultaneous push/pop on empty: acts as push.
        step(1'b1, 5'h12, 1'b1, 1'b0);
        check_all("t4_pp_empty");
        step(1'b0, 5'h00, 1'b1, 1'b0);

        // 5. Asynchronous reset between edges.
        step(1'b1, 5'h01, 1'b0, 1'b0);
        step(1'b1, 5'h02, 1'b0, 1'b0);
        step(1'b1, 5'h03, 1'b0, 1'b0);
        #2;
        do_reset();
        #1;
        check_all("t5_async_rst");
        chk("t5_level_0", {4'b0000, level}, 8'h00);
        @(negedge clk);
        rst_ = 1'b1;
        step(1'b1, 5'h04, 1'b0, 1'b0);
        check_all("t5_after_rst");
        chk("t5_top_04", {3'b000, top}, 8'h04);

        // 6. Random traffic against the queue model.
        for (int n = 0; n < 10000; n++) begin
            logic [1:0] r;
            r = 2'($urandom_range(0, 3));
            step(r[0], 5'($urandom_range(0, 31)), r[1], ($urandom_range(0, 15) == 0));
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_return_stack
